// File: rtl/sid_i2s_tx.sv
// Stereo I2S (Philips) transmitter for the SID audio output: 32-bit slots, self-generated
// BCK/LRCK, sample holding register with sticky overrun detection.
package sid;
  typedef struct packed {
    logic signed [23:0] left;
    logic signed [23:0] right;
  } audio_t;
endpackage

module sid_i2s_tx
  import sid::*;
#(
  parameter int HALF_DIV = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  audio_t audio_i,
  input  logic   valid_i,
  output logic   frame_o,
  output logic   overrun_o,
  output logic   i2s_bck,
  output logic   i2s_lrck,
  output logic   i2s_sd
);

  localparam int DW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [DW-1:0] r_div_cnt;
  logic          r_bck;
  logic [5:0]    r_bit_cnt;
  logic          r_lrck;
  logic          r_sd;
  logic          r_frame;
  logic          r_overrun;
  logic          r_pending;
  audio_t        r_hold;
  logic [63:0]   r_shift;

  logic          w_div_wrap;
  logic          w_fall;
  logic          w_load;
  logic [5:0]    w_bit_nxt;
  logic [63:0]   w_frame_word;

  assign w_div_wrap   = (r_div_cnt == DW'(HALF_DIV - 1));
  assign w_fall       = w_div_wrap & r_bck;
  assign w_load       = w_fall & (r_bit_cnt == 6'd63);
  assign w_bit_nxt    = r_bit_cnt + 6'd1;
  assign w_frame_word = {r_hold.left, 8'h00, r_hold.right, 8'h00};

  // BCK generation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_bck     <= 1'b0;
    end else begin
      r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
      if (w_div_wrap) r_bck <= ~r_bck;
    end
  end

  // Everything on the serial side advances on BCK falling edges only, so the DAC
  // sees HALF_DIV clk cycles of setup and hold around each rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= 6'd63;
      r_lrck    <= 1'b1;
      r_sd      <= 1'b0;
      r_shift   <= '0;
      r_frame   <= 1'b0;
    end else begin
      r_frame <= w_load;
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrck    <= w_bit_nxt[5];
        // Shifter MSB is the previous frame bit, giving the one-BCK delay after LRCK;
        // at the load edge it is still bit 63 of the outgoing frame.
        r_sd      <= r_shift[63];
        r_shift   <= w_load ? w_frame_word : {r_shift[62:0], 1'b0};
      end
    end
  end

  // A strobe on the load edge lands in the holding register after the shifter has
  // taken the old value, so it stays pending and is not counted as an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold    <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (valid_i) begin
        r_hold    <= audio_i;
        r_pending <= 1'b1;
        if (r_pending && !w_load) r_overrun <= 1'b1;
      end else if (w_load) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign i2s_bck   = r_bck;
  assign i2s_lrck  = r_lrck;
  assign i2s_sd    = r_sd;
  assign frame_o   = r_frame;
  assign overrun_o = r_overrun;

endmodule

// File: tb/tb_sid_i2s_tx.sv
// Directed bench for sid_i2s_tx: a monitor reassembles each frame from i2s_sd sampled on
// BCK rising edges and per-scenario tasks compare against hand-computed frames.
module tb_sid_i2s_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  sid::audio_t audio;
  logic        valid = 1'b0;
  logic        frame_o, overrun_o, i2s_bck, i2s_lrck, i2s_sd;

  int n_chk  = 0;
  int n_pass = 0;

  sid_i2s_tx #(.HALF_DIV(4)) dut (
    .clk(clk), .rst(rst), .audio_i(audio), .valid_i(valid),
    .frame_o(frame_o), .overrun_o(overrun_o),
    .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck), .i2s_sd(i2s_sd)
  );

  always #5 clk = ~clk;

  // Frame monitor: idx -2 idle, -1 next rise is slot k=0, otherwise frame bit idx is next.
  logic [63:0] frames[$];
  logic [63:0] cap = '0;
  int          idx = -2;
  bit          have = 0;
  logic        prev_bck = 1'b0;
  int          lrck_err = 0;

  always @(negedge clk) begin
    if (rst) begin
      idx      <= -2;
      have     <= 0;
      prev_bck <= 1'b0;
    end else begin
      if (frame_o) idx <= -1;
      else if (i2s_bck && !prev_bck && idx != -2) begin
        if (idx == -1) begin
          if (have) frames.push_back({cap[62:0], i2s_sd});
          if (i2s_lrck !== 1'b0) lrck_err <= lrck_err + 1;
          idx  <= 0;
          have <= 1;
        end else begin
          cap <= {cap[62:0], i2s_sd};
          if (i2s_lrck !== ((idx + 1) >= 32)) lrck_err <= lrck_err + 1;
          idx <= idx + 1;
        end
      end
      prev_bck <= i2s_bck;
    end
  end

  function automatic logic [63:0] mkf(input logic [23:0] l, input logic [23:0] r);
    return {l, 8'h00, r, 8'h00};
  endfunction

  task automatic send(input logic [23:0] l, input logic [23:0] r);
    audio.left  = l;
    audio.right = r;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, output bit ok);
    ok = 0;
    for (int c = 0; c < 600 * (n + 2); c++) begin
      if (frames.size() >= n) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_frame_o(output bit ok);
    ok = 0;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      if (frame_o === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_chk++; if (i2s_bck !== 1'b0) $display("FAIL rst_bck got %b exp 0", i2s_bck); else n_pass++;
    n_chk++; if (i2s_lrck !== 1'b1) $display("FAIL rst_lrck got %b exp 1", i2s_lrck); else n_pass++;
    n_chk++; if (i2s_sd !== 1'b0) $display("FAIL rst_sd got %b exp 0", i2s_sd); else n_pass++;
    n_chk++; if (frame_o !== 1'b0) $display("FAIL rst_frame got %b exp 0", frame_o); else n_pass++;
    n_chk++; if (overrun_o !== 1'b0) $display("FAIL rst_overrun got %b exp 0", overrun_o); else n_pass++;
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      if (e == 3) begin
        n_chk++; if (i2s_bck !== 1'b0) $display("FAIL edge3_bck got %b exp 0", i2s_bck); else n_pass++;
      end
      if (e == 4) begin
        n_chk++; if (i2s_bck !== 1'b1) $display("FAIL edge4_bck got %b exp 1", i2s_bck); else n_pass++;
      end
      if (e == 7) begin
        n_chk++; if (frame_o !== 1'b0) $display("FAIL edge7_frame got %b exp 0", frame_o); else n_pass++;
      end
      if (e == 8) begin
        n_chk++; if (i2s_bck !== 1'b0) $display("FAIL edge8_bck got %b exp 0", i2s_bck); else n_pass++;
        n_chk++; if (frame_o !== 1'b1) $display("FAIL edge8_frame got %b exp 1", frame_o); else n_pass++;
        n_chk++; if (i2s_lrck !== 1'b0) $display("FAIL edge8_lrck got %b exp 0", i2s_lrck); else n_pass++;
      end
      if (e == 9) begin
        n_chk++; if (frame_o !== 1'b0) $display("FAIL edge9_frame got %b exp 0", frame_o); else n_pass++;
      end
    end
  endtask

  task automatic test_single;
    bit ok;
    frames.delete();
    send(24'h800001, 24'h7FFFFE);
    wait_frames(2, ok);
    n_chk++;
    if (!ok) $display("FAIL single_timeout got %0d frames exp 2", frames.size());
    else begin
      n_pass++;
      n_chk++; if (frames[0] !== 64'h0) $display("FAIL single_first got %h exp 0", frames[0]); else n_pass++;
      n_chk++; if (frames[1] !== 64'h80000100_7FFFFE00)
        $display("FAIL single_data got %h exp 800001007ffffe00", frames[1]); else n_pass++;
    end
  endtask

  task automatic test_repeat;
    bit ok;
    frames.delete();
    wait_frames(3, ok);
    n_chk++;
    if (!ok) $display("FAIL repeat_timeout got %0d frames exp 3", frames.size());
    else begin
      n_pass++;
      for (int i = 0; i < 3; i++) begin
        n_chk++; if (frames[i] !== mkf(24'h800001, 24'h7FFFFE))
          $display("FAIL repeat_frame%0d got %h exp 800001007ffffe00", i, frames[i]); else n_pass++;
      end
    end
    n_chk++; if (overrun_o !== 1'b0) $display("FAIL repeat_overrun got %b exp 0", overrun_o); else n_pass++;
    n_chk++; if (lrck_err !== 0) $display("FAIL lrck_slots got %0d errors exp 0", lrck_err); else n_pass++;
  endtask

  task automatic test_overrun;
    bit ok;
    frames.delete();
    send(24'h000111, 24'h0000AA);
    repeat (10) @(negedge clk);
    send(24'h000222, 24'h0000AA);
    n_chk++; if (overrun_o !== 1'b1) $display("FAIL overrun_set got %b exp 1", overrun_o); else n_pass++;
    wait_frames(2, ok);
    n_chk++;
    if (!ok) $display("FAIL overrun_timeout got %0d frames exp 2", frames.size());
    else begin
      n_pass++;
      n_chk++; if (frames[0] !== mkf(24'h800001, 24'h7FFFFE))
        $display("FAIL overrun_cur got %h exp 800001007ffffe00", frames[0]); else n_pass++;
      n_chk++; if (frames[1] !== mkf(24'h000222, 24'h0000AA))
        $display("FAIL overrun_next got %h exp %h", frames[1], mkf(24'h000222, 24'h0000AA)); else n_pass++;
    end
    n_chk++; if (overrun_o !== 1'b1) $display("FAIL overrun_sticky got %b exp 1", overrun_o); else n_pass++;
  endtask

  task automatic test_reset_midframe;
    bit ok;
    wait_frame_o(ok);
    n_chk++; if (!ok) $display("FAIL mid_frame_o_timeout got 0 exp 1"); else n_pass++;
    // bit_cnt reaches 40 after 320 cycles; 4 more puts BCK high within that slot
    repeat (324) @(negedge clk);
    n_chk++; if (i2s_bck !== 1'b1) $display("FAIL mid_pre_bck got %b exp 1", i2s_bck); else n_pass++;
    n_chk++; if (i2s_lrck !== 1'b1) $display("FAIL mid_pre_lrck got %b exp 1", i2s_lrck); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (i2s_bck !== 1'b0) $display("FAIL mid_async_bck got %b exp 0", i2s_bck); else n_pass++;
    n_chk++; if (overrun_o !== 1'b0) $display("FAIL mid_async_overrun got %b exp 0", overrun_o); else n_pass++;
    n_chk++; if (i2s_sd !== 1'b0) $display("FAIL mid_async_sd got %b exp 0", i2s_sd); else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      if (e == 4) begin
        n_chk++; if (i2s_bck !== 1'b1) $display("FAIL mid_edge4_bck got %b exp 1", i2s_bck); else n_pass++;
      end
      if (e == 8) begin
        n_chk++; if (frame_o !== 1'b1 || i2s_lrck !== 1'b0)
          $display("FAIL mid_edge8 got frame=%b lrck=%b exp frame=1 lrck=0", frame_o, i2s_lrck); else n_pass++;
      end
    end
    frames.delete();
    wait_frames(1, ok);
    n_chk++;
    if (!ok) $display("FAIL mid_timeout got %0d frames exp 1", frames.size());
    else begin
      n_pass++;
      n_chk++; if (frames[0] !== 64'h0) $display("FAIL mid_zero_frame got %h exp 0", frames[0]); else n_pass++;
    end
  endtask

  task automatic test_coincident;
    bit ok;
    wait_frame_o(ok);
    n_chk++; if (!ok) $display("FAIL coin_frame_o_timeout got 0 exp 1"); else n_pass++;
    frames.delete();
    send(24'h0ABCDE, 24'h135790);   // left pending through the next load edge
    repeat (510) @(negedge clk);
    audio.left  = 24'h123456;
    audio.right = 24'h654321;
    valid = 1'b1;                   // sampled on the very edge that loads the shifter
    @(negedge clk);
    valid = 1'b0;
    n_chk++; if (frame_o !== 1'b1) $display("FAIL coin_align got frame=%b exp 1", frame_o); else n_pass++;
    wait_frames(4, ok);
    n_chk++;
    if (!ok) $display("FAIL coin_timeout got %0d frames exp 4", frames.size());
    else begin
      n_pass++;
      n_chk++; if (frames[1] !== 64'h0) $display("FAIL coin_prev got %h exp 0", frames[1]); else n_pass++;
      n_chk++; if (frames[2] !== mkf(24'h0ABCDE, 24'h135790))
        $display("FAIL coin_cur got %h exp %h", frames[2], mkf(24'h0ABCDE, 24'h135790)); else n_pass++;
      n_chk++; if (frames[3] !== mkf(24'h123456, 24'h654321))
        $display("FAIL coin_next got %h exp %h", frames[3], mkf(24'h123456, 24'h654321)); else n_pass++;
    end
    n_chk++; if (overrun_o !== 1'b0) $display("FAIL coin_overrun got %b exp 0", overrun_o); else n_pass++;
    n_chk++; if (lrck_err !== 0) $display("FAIL lrck_slots_end got %0d errors exp 0", lrck_err); else n_pass++;
  endtask

  initial begin
    audio = '0;
    test_reset();
    test_single();
    test_repeat();
    test_overrun();
    test_reset_midframe();
    test_coincident();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sid_i2s_tx.md
# sid_i2s_tx

Stereo I2S transmitter that carries the two 24-bit signed SID audio outputs, `audio_o.left` and `audio_o.right`, to the external DAC. It captures a new stereo sample whenever the audio pipeline strobes one. It then serializes the sample continuously in Philips I2S format, using 32-bit slots and generating its own bit clock and word clock from `clk`. It is the consumer end of the SID audio output interface and sits between the SID API block and the DAC pins.

## Interface
- `HALF_DIV`, default 4: number of `clk` cycles per BCK half-period. Must be at least 1. BCK frequency is clk/(2·HALF_DIV); one frame is 128·HALF_DIV clk cycles.
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high
- `audio_i`  in  sid::audio_t  stereo sample; `.left` and `.right` are each 24-bit signed
- `valid_i`  in  1  one-cycle strobe; `audio_i` is valid on this cycle
- `frame_o`  out  1  one-cycle pulse when a frame is loaded into the shifter (acts as a sample request)
- `overrun_o`  out  1  sticky flag: a sample was overwritten before it was transmitted
- `i2s_bck`  out  1  bit clock
- `i2s_lrck`  out  1  word select; 0 = left, 1 = right
- `i2s_sd`  out  1  serial data, MSB first

## Operation
- **Divider.** `div_cnt` counts 0..HALF_DIV-1. On each wrap, `i2s_bck` toggles.
- **Bit counter.** `bit_cnt` is 6 bits. It increments, modulo 64, on every BCK falling edge, i.e. on the clk cycle where `i2s_bck` goes 1→0.
- **Holding register.** On `valid_i`, `{left,right}` is captured into the holding register and a `pending` flag is set.
- **Frame load.** Occurs on the falling edge where `bit_cnt` becomes 0.
  - The 64-bit shifter is loaded with {left[23:0], 8'h00, right[23:0], 8'h00} from the holding value as it stood *before* that clk edge.
  - `pending` clears.
  - `frame_o` pulses for that one clk cycle.
- **No new sample.** If no new sample arrived, the previous holding value is retransmitted.
- **Outputs per falling edge.** On each falling edge, with k = the new `bit_cnt`:
  - `i2s_lrck` = k[5].
  - `i2s_sd` = frame bit (k-1) mod 64, where frame bit 0 is left[23].
  - This gives the standard one-BCK delay of data after an LRCK transition.
  - The last frame bit (bit 63, zero padding) goes out at k=0 of the following frame.
- **Overrun.** If `valid_i` arrives while `pending`=1, the newer sample overwrites the older one and `overrun_o` sets. `overrun_o` clears only on `rst`.
- **valid_i on the frame-load cycle.** If `valid_i` coincides with the frame-load cycle:
  - the shifter takes the old holding value;
  - the new sample is stored with `pending`=1;
  - there is no overrun.
- **Outputs are registered.** `i2s_bck`, `i2s_lrck`, `i2s_sd` and `frame_o` are driven directly from flops, with no combinational path from inputs.

## Timing
- **Reset values:**
  - `i2s_bck`=0, `i2s_lrck`=1, `i2s_sd`=0
  - `frame_o`=0, `overrun_o`=0
  - `div_cnt`=0, `bit_cnt`=63
  - holding register=0, shifter=0, `pending`=0
- **First edges after rst deasserts:**
  - first BCK rise at clk edge HALF_DIV;
  - first fall at clk edge 2·HALF_DIV;
  - that fall gives `bit_cnt`=0, `i2s_lrck`=0 and the first `frame_o` pulse.
- **Data timing.**
  - `i2s_sd` and `i2s_lrck` change only on BCK falling edges. The DAC samples them on rising edges.
  - Setup and hold at the DAC are each HALF_DIV clk cycles.
- **Latency.** From `valid_i` to the left MSB on `i2s_sd` is at most one frame plus one BCK period, i.e. 130·HALF_DIV clk cycles.
- **Reset mid-frame.**
  - All state returns to reset values immediately, because reset is asynchronous.
  - Outputs may glitch low/high once, which is acceptable.
  - The next frame starts cleanly per the first-edges timing above.
- **HALF_DIV=1.** BCK toggles every clk cycle and frames are 128 clk cycles long. All rules above still hold.

## Test plan
- **Reset values.** Assert `rst` for 3 cycles → all outputs at reset values. Release, with HALF_DIV=4 → BCK rises at clk 4, falls at clk 8 with `frame_o`=1 and `i2s_lrck`=0.
- **Single sample.** Send `valid_i` with left=24'h800001, right=24'h7FFFFE before the second frame. Sampling `i2s_sd` on BCK rising edges then gives:
  - `i2s_lrck`=0 slot, after the one-bit delay: 1, 22×0, 1, 8×0;
  - `i2s_lrck`=1 slot: 0, 22×1, 0, 8×0.
- **Repeat.** No further `valid_i` for 3 frames → the same 64-bit pattern repeats each frame, and `overrun_o` stays 0.
- **Overrun.** Two `valid_i` strobes within one frame, with left=24'h000111 then left=24'h000222 → the next frame carries 24'h000222 and `overrun_o`=1 until `rst`.
- **Coincident strobe.** `valid_i` with left=24'h123456 on the exact `frame_o` cycle:
  - the current frame carries the previous sample;
  - the next frame carries 24'h123456;
  - `overrun_o`=0.
- **Reset mid-frame.** Assert `rst` at `bit_cnt`=40 → outputs return to reset values asynchronously. After release, the first frame is all-zero data with correct BCK/LRCK timing.
